nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 120 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder built from one 4-bit slice with a
// registered carry, one nibble per clock, LSB nibble first. Result, carry
// and signed overflow are presented with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the start edge
// RUN   | one nibble added per clock, carry held in carry_reg
// DONE  | result valid, done high for this single cycle
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] partial_nxt;
    logic             carry_reg;
    logic [IW-1:0]    idx;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       slice;
    logic             last;

    assign last = (idx == IW'(NIBBLES - 1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The single 4-bit slice and the partial result with the current nibble merged in.
    always_comb begin
        a_nib       = a_reg[4*idx +: 4];
        b_nib       = b_reg[4*idx +: 4];
        slice       = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_reg};
        partial_nxt = partial;
        partial_nxt[4*idx +: 4] = slice[3:0];
    end

    // Operand capture, nibble sequencing and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            partial   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= ci;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    partial   <= partial_nxt;
                    carry_reg <= slice[4];
                    if (last) begin
                        // idx parks at 0 so the slice never indexes past the MSB nibble.
                        idx      <= '0;
                        sum      <= partial_nxt;
                        carry    <= slice[4];
                        overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                    (partial_nxt[WIDTH-1] != a_reg[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vector
// table, random operations against an arithmetic reference model, and
// hand-written sequences for busy protection and mid-run reset.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int LAT   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    // Result the outputs should hold between completions.
    logic [WIDTH-1:0] held_sum;
    logic             held_carry;
    logic             held_ovf;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: plain wide arithmetic.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mci,
                         output logic [WIDTH-1:0] ms, output logic mc, output logic mv);
        logic [WIDTH:0] full;
        full = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mci};
        ms = full[WIDTH-1:0];
        mc = full[WIDTH];
        mv = (ma[WIDTH-1] == mb[WIDTH-1]) && (ms[WIDTH-1] != ma[WIDTH-1]);
    endtask

    // Called at a negedge while idle; returns at the negedge after the done cycle.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                          input logic oci, input logic [WIDTH-1:0] es, input logic ec, input logic ev);
        int cnt;
        start = 1'b1; a = oa; b = ob; ci = oci;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom);
        check({tag, " busy after start"}, busy, 1);
        cnt = 0;
        while (!done && cnt < 20) begin
            check({tag, " sum held during run"}, {carry, overflow, sum}, {held_carry, held_ovf, held_sum});
            @(negedge clk);
            cnt++;
        end
        check({tag, " latency"}, cnt, LAT);
        check({tag, " sum"}, sum, es);
        check({tag, " carry"}, carry, ec);
        check({tag, " overflow"}, overflow, ev);
        held_sum = es; held_carry = ec; held_ovf = ev;
        @(negedge clk);
        check({tag, " idle after done"}, {busy, done}, 2'b00);
        check({tag, " result held"}, sum, es);
    endtask

    vec_t vecs[8];

    initial begin
        logic [WIDTH-1:0] rs;
        logic             rc;
        logic             rv;
        int               npulse;
        logic [WIDTH-1:0] psum;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        held_sum = '0; held_carry = 1'b0; held_ovf = 1'b0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset state", {busy, done, carry, overflow, sum}, '0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci,
                   vecs[i].s, vecs[i].c, vecs[i].v);
        end

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rci;
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rci = 1'($urandom);
            if (i % 8 == 0) rb = ~ra;
            model(ra, rb, rci, rs, rc, rv);
            run_op($sformatf("rand%0d", i), ra, rb, rci, rs, rc, rv);
        end

        // Busy protection: start held high for the whole RUN and DONE window.
        start = 1'b1; a = 16'h0008; b = 16'h0009; ci = 1'b0;
        npulse = 0; psum = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                npulse++;
                psum = sum;
            end
            a = 16'h1111; b = 16'h2222;
            start = busy;
        end
        check("busy single pulse", npulse, 1);
        check("busy sum", psum, 16'h0011);
        check("busy not restarted", busy, 0);
        held_sum = 16'h0011; held_carry = 1'b0; held_ovf = 1'b0;
        run_op("after busy", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

        // Reset mid-run, asserted between clock edges.
        start = 1'b1; a = 16'h00FF; b = 16'h0001; ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", {busy, done, carry, overflow, sum}, '0);
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        check("no done after reset", npulse, 0);
        check("reset sum stays zero", sum, 16'h0000);
        held_sum = '0; held_carry = 1'b0; held_ovf = 1'b0;
        run_op("post reset", 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
